// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: op codes, op width and FSM states.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_PASS_B = 4'b0000,
        OP_ADD    = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_AND    = 4'b0100,
        OP_OR     = 4'b0101,
        OP_XOR    = 4'b0110,
        OP_LSL    = 4'b0111,
        OP_LSR    = 4'b1000,
        OP_ASR    = 4'b1001,
        OP_MUL    = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 shift-add multiplier (low WIDTH bits, unsigned).
// Optional build macro: ALU_MUL_EARLY_TERM_EN stops after the highest set bit of b.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             busy;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] steps;

`ifdef ALU_MUL_EARLY_TERM_EN
    // Step count = position of highest set bit of b plus one, never below one.
    always_comb begin
        steps = CNT_W'(1);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (b[i]) steps = CNT_W'(i + 1);
        end
    end
`else
    assign steps = CNT_W'(WIDTH);
`endif

    // done marks the cycle whose edge performs the final step; result is that step's sum.
    assign done   = busy && (count == CNT_W'(1));
    assign result = acc + (mplier[0] ? mcand : '0);

    // Load on start, then one shift-add step per cycle until the count expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= steps;
        end else if (busy) begin
            acc    <= result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Pipelined ALU execution unit: valid/ready issue port, registered result with NZVC.
// Optional build macro: ALU_MUL_EARLY_TERM_EN (early-terminating multiply).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_negative,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_carry
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state;
    alu_op_e          op;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;

    assign op        = alu_op_e'(in_op);
    assign in_ready  = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign out_valid = (state == HOLD);

    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~in_b : in_b;
    assign sum    = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sh     = in_b[SH_W-1:0];

    // Single-cycle datapath; unknown codes fall through to PASS_B.
    always_comb begin
        alu_res = in_b;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_LSL:  alu_res = in_a << sh;
            OP_LSR:  alu_res = in_a >> sh;
            OP_ASR:  alu_res = $unsigned($signed(in_a) >>> sh);
            default: alu_res = in_b;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .abort   (flush),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .result  (mul_result)
    );

    // accept already implies IDLE or a draining HOLD, so it is checked first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            out_result   <= '0;
            out_tag      <= '0;
            out_negative <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            out_tag <= in_tag;
            if (op == OP_MUL) begin
                state <= MUL;
            end else begin
                state        <= HOLD;
                out_result   <= alu_res;
                out_negative <= alu_res[WIDTH-1];
                out_zero     <= (alu_res == '0);
                out_overflow <= alu_v;
                out_carry    <= alu_c;
            end
        end else if ((state == MUL) && mul_done) begin
            state        <= HOLD;
            out_result   <= mul_result;
            out_negative <= mul_result[WIDTH-1];
            out_zero     <= (mul_result == '0);
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results, monitor pops on transfer.
module tb_alu_exec_unit;

    localparam int W  = 64;
    localparam int TW = 6;

    typedef struct packed {
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          n;
        logic          z;
        logic          v;
        logic          c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_negative;
    logic          out_zero;
    logic          out_overflow;
    logic          out_carry;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    exp_t scb[$];

    alu_exec_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_negative (out_negative),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_carry    (out_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    // Reference: architectural meaning of each op in plain wide arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t              e;
        logic signed [65:0] sa, sbv, s;
        logic [5:0]        sh;
        e     = '0;
        e.tag = tag;
        sh    = b[5:0];
        sa    = $signed({{2{a[W-1]}}, a});
        sbv   = $signed({{2{b[W-1]}}, b});
        case (op)
            4'h2: begin
                e.r = a + b;
                e.c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                s   = sa + sbv;
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h3: begin
                e.r = a - b;
                e.c = (a >= b);
                s   = sa - sbv;
                e.v = (s > SMAX) || (s < SMIN);
            end
            4'h4: e.r = a & b;
            4'h5: e.r = a | b;
            4'h6: e.r = a ^ b;
            4'h7: e.r = a << sh;
            4'h8: e.r = a >> sh;
            4'h9: e.r = $unsigned($signed(a) >>> sh);
            4'hA: e.r = a * b;
            default: e.r = b;
        endcase
        e.n = e.r[W-1];
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic int mul_latency(input logic [W-1:0] b);
        int steps;
        steps = W;
`ifdef ALU_MUL_EARLY_TERM_EN
        steps = 1;
        for (int i = 0; i < W; i++) if (b[i]) steps = i + 1;
`endif
        return steps + 1;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one op starting at a negedge; returns at the negedge after the accept edge.
    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input bit rnd_ready);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        while (!done) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                scb.push_back(model(op, a, b, tag));
                acc_edge = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: op %h not accepted within %0d cycles", op, n);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every transfer on the result port must match the oldest expectation.
    always @(negedge clk) begin
        exp_t got, e;
        #2;
        if (reset_n && out_valid && out_ready && !flush) begin
            got = {out_result, out_tag, out_negative, out_zero, out_overflow, out_carry};
            checks++;
            if (scb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got r=%h tag=%h required none", out_result, out_tag);
            end else begin
                e = scb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result: got r=%h tag=%h nzvc=%b%b%b%b required r=%h tag=%h nzvc=%b%b%b%b",
                             got.r, got.tag, got.n, got.z, got.v, got.c, e.r, e.tag, e.n, e.z, e.v, e.c);
                end
            end
        end
    end

    initial begin
        exp_t e1;
        int   n;
        int   seen;
        logic [W-1:0] ra, rb;
        logic [3:0]   rop;

        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_zero", W'(out_zero), W'(0));
        chk("rst_out_result", out_result, W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        reset_n = 1'b1;
        @(negedge clk);

        // ADD overflow corner, latency 1
        drive(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 6'd5, 1'b0);
        chk("add_latency", W'(cyc - acc_edge + 1), W'(1));
        chk("add_valid", W'(out_valid), W'(1));
        chk("add_v", W'(out_overflow), W'(1));
        drive(4'h3, 64'h45_BDE7_3621, 64'h45_BDE7_3621, 6'd6, 1'b0);
        chk("sub_zc", W'({out_zero, out_carry, out_overflow}), W'(3'b110));
        drive(4'h9, 64'h8000_0000_0000_0000, 64'd63, 6'd7, 1'b0);
        chk("asr_res", out_result, {W{1'b1}});

        // Back-pressure: first result held, second op blocked until drain
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'h2, 64'd100, 64'd23, 6'd8, 1'b0);
        e1 = model(4'h2, 64'd100, 64'd23, 6'd8);
        in_valid = 1'b1; in_op = 4'h2; in_a = 64'd1; in_b = 64'd2; in_tag = 6'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_hold", out_result, e1.r);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drive(4'h2, 64'd1, 64'd2, 6'd9, 1'b0);
        @(negedge clk);

        // MUL latency, in_ready low while iterating
        drive(4'hA, 64'h1234, 64'h10, 6'd10, 1'b0);
        n = 0;
        while (!out_valid && n < 300) begin
            if (n == 2) chk("mul_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
            n++;
        end
        chk("mul_latency", W'(cyc - acc_edge + 1), W'(mul_latency(64'h10)));
        chk("mul_res", out_result, 64'h12340);
        @(negedge clk);

        // Flush mid-MUL
        drive(4'hA, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd11, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", W'(in_ready), W'(0));
        scb.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_ready", W'(in_ready), W'(1));
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", W'(seen), W'(0));
        drive(4'h2, 64'd3, 64'd4, 6'd12, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-MUL
        drive(4'hA, 64'd77, 64'hFFFF, 6'd13, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("amid_rst_valid", W'(out_valid), W'(0));
        chk("amid_rst_result", out_result, W'(0));
        scb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(4'h4, {W{1'b1}}, 64'd0, 6'd14, 1'b0);
        chk("and_zero", W'(out_zero), W'(1));

        // Randomized ops with random back-pressure
        for (int k = 0; k < 250; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 255));
            drive(rop, ra, rb, TW'($urandom), 1'b1);
        end

        out_ready = 1'b1;
        n = 0;
        while (scb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", W'(scb.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised, pipelined ALU execution unit for the out-of-order core. It sits between a reservation station issue port and the common data bus (CDB) arbiter. It accepts one tagged operation per cycle through a valid/ready handshake and produces a registered result with NZVC flags. It supersedes the bare combinational ALU by adding shifts, an iterative multiply, back-pressure and flush.

Parameters:
WIDTH, 64, operand/result width; must be >= 8 and a power of two
TAG_W, 6, width of the ROB/physical-register tag carried alongside each op
SH_W, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  issue port holds a valid op
in_ready  output  1  unit accepts the op this cycle
in_op  input  4  operation code (alu_op_e)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B / shift amount
in_tag  input  TAG_W  destination tag
flush  input  1  squash all in-flight and held work
out_valid  output  1  result register holds a valid result
out_ready  input  1  CDB accepts the result this cycle
out_result  output  WIDTH  result
out_tag  output  TAG_W  tag of the result
out_negative  output  1  out_result MSB
out_zero  output  1  out_result == 0
out_overflow  output  1  signed overflow (ADD/SUB only, else 0)
out_carry  output  1  carry-out (ADD/SUB only, else 0)

Behaviour:
- Op codes: 0000 PASS_B, 0010 ADD, 0011 SUB (A+~B+1), 0100 AND, 0101 OR, 0110 XOR, 0111 LSL, 1000 LSR, 1001 ASR, 1010 MUL (low WIDTH bits of A*B, unsigned). All other codes execute as PASS_B.
- Shifts use in_b[SH_W-1:0] only; upper bits ignored.
- ADD/SUB: carry is the carry out of bit WIDTH-1; overflow = carry-in(MSB) XOR carry-out(MSB). SUB with A==B gives carry=1 and zero=1.
- FSM states:
  - IDLE: output empty.
  - MUL: iterating.
  - HOLD: out_valid=1.
- Handshake: accept = in_valid & in_ready. in_ready = !flush & (IDLE | (HOLD & out_ready)). A result leaves on out_valid & out_ready.
- Single-cycle ops: accept edge -> HOLD. out_valid is high the next cycle (latency 1). Full throughput when out_ready stays high.
- MUL: accept edge loads the multiplicand, multiplier and accumulator, and sets counter=WIDTH. One radix-2 shift-add step per cycle. After the final step the FSM enters HOLD. Latency WIDTH+1 cycles. in_ready=0 throughout MUL.
- HOLD with out_ready=0: all out_* are held stable and in_ready=0.
- HOLD with out_ready=1 and a new accept in the same cycle: the new result/tag replaces the old on that edge (no bubble).
- flush (synchronous): next state is IDLE, out_valid=0, any MUL is abandoned. flush wins over out_ready and in_valid in the same cycle.
- Reset: on reset_n low, asynchronously, FSM=IDLE and all out_* = 0. This includes out_valid=0 and out_zero=0. in_ready then reads 1 (unless flush is high). Reset mid-MUL discards the operation.
- Flags are registered together with out_result. MUL/logic/shift/PASS_B drive out_overflow=out_carry=0.

Optional Feature:
ALU_MUL_EARLY_TERM_EN:
- When defined: the MUL step count is the bit position of the highest set bit of B, plus 1 (minimum 1). Latency is therefore that count + 1, e.g. B=0x10 gives 5 steps and latency 6. B=0 gives 1 step and a result of 0.
- When undefined: always WIDTH steps, latency WIDTH+1.
- Results are identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the codes above;
  - localparam ALU_OP_W = 4;
  - the FSM state typedef alu_state_e {IDLE, MUL, HOLD}.
- Sub-module alu_mul_iter: the iterative shift-add multiplier, with start/done handshake, internal step counter and the early-terminate logic.
- The combinational datapath (add/logic/shift) stays inline in alu_exec_unit.

Test Plan:
- ADD A=0x7FFFFFFFFFFFFFFF, B=1, tag=5 -> out_valid the next cycle, result 0x8000000000000000, N=1, Z=0, V=1, C=0, tag=5.
- SUB A=B=0x45BDE73621 -> result 0, Z=1, C=1, V=0; ASR A=0x8000000000000000, B=63 -> result 0xFFFFFFFFFFFFFFFF, N=1.
- Two back-to-back ADDs with out_ready=0 -> first result held stable, in_ready=0. Raise out_ready -> both results delivered in order on consecutive cycles.
- MUL A=0x1234, B=0x10 -> result 0x12340. out_valid rises after 65 cycles (no macro) or 6 cycles (ALU_MUL_EARLY_TERM_EN). in_ready=0 meanwhile.
- MUL accepted, flush pulsed 10 cycles later -> out_valid never rises, in_ready=1 the cycle after the flush, next ADD is processed normally.
- reset_n driven low mid-MUL (asynchronously, between clock edges) -> out_valid/out_result go to 0 immediately. After release, an AND of 0xFFFF.., 0 gives Z=1.
